// File: rtl/code_preimage_search_pkg.sv
// Shared definitions for the code preimage search block: widths, the forward
// code map table (single source) and the search state encoding.
package code_preimage_search_pkg;

   localparam int unsigned CODE_W = 4;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned N_CAND = 16;

   typedef logic [CODE_W-1:0] code_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Forward map F(x) for x = 0..15
   localparam code_t FWD_TABLE [N_CAND] = '{
      4'd2,  4'd3,  4'd8,  4'd0,  4'd3,  4'd11, 4'd10, 4'd13,
      4'd9,  4'd15, 4'd12, 4'd7,  4'd1,  4'd2,  4'd1,  4'd4
   };

   function automatic code_t fwd_map(input code_t x);
      return FWD_TABLE[x];
   endfunction

endpackage

// File: rtl/code_preimage_search_if.sv
// Request/result handshake bundle for code_preimage_search.
interface code_preimage_search_if;
   import code_preimage_search_pkg::*;

   logic  in_valid;
   logic  in_ready;
   code_t in_code;
   logic  out_valid;
   logic  out_ready;
   logic  out_found;
   code_t out_x;
   cnt_t  out_count;
   logic  out_multi;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_found, out_x, out_count, out_multi
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_found, out_x, out_count, out_multi
   );

endinterface

// File: rtl/fwd_code_map.sv
// Combinational forward code map lookup y = F(x).
module fwd_code_map
   import code_preimage_search_pkg::*;
(
   input  code_t x,
   output code_t y_c
);

   assign y_c = fwd_map(x);

endmodule

// File: rtl/code_preimage_search.sv
// Sequential inverse of the forward code map: scans one candidate per clock and
// reports the smallest preimage, the preimage count and found/ambiguous flags.
module code_preimage_search
   import code_preimage_search_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   code_preimage_search_if.slave bus
);

   state_e state_q, state_d;
   code_t  code_q, code_d;
   code_t  idx_q, idx_d;
   code_t  x_q, x_d;
   cnt_t   count_q, count_d;
   logic   found_q, found_d;
   logic   in_ready_q, in_ready_d;
   logic   out_valid_q, out_valid_d;
   code_t  cand_y_c;
   logic   match_c;

   fwd_code_map u_fwd_code_map (
      .x   (idx_q),
      .y_c (cand_y_c)
   );

   assign match_c = (cand_y_c == code_q);

   // Next-state, accumulator and handshake logic
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      idx_d    = idx_q;
      x_d      = x_q;
      count_d  = count_q;
      found_d  = found_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               code_d  = bus.in_code;
               idx_d   = '0;
               x_d     = '0;
               count_d = '0;
               found_d = 1'b0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (match_c) begin
               count_d = count_q + CNT_W'(1);
               if (!found_q) begin
                  found_d = 1'b1;
                  x_d     = idx_q;
               end
            end
            if ((idx_q == CODE_W'(N_CAND - 1)) || (EARLY_EXIT && match_c)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + CODE_W'(1);
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake flags track the state being entered so they are registered
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         code_q      <= '0;
         idx_q       <= '0;
         x_q         <= '0;
         count_q     <= '0;
         found_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         idx_q       <= idx_d;
         x_q         <= x_d;
         count_q     <= count_d;
         found_q     <= found_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_found = found_q;
   assign bus.out_x     = x_q;
   assign bus.out_count = count_q;
   assign bus.out_multi = (count_q > CNT_W'(1));

endmodule

// File: tb/tb_code_preimage_search.sv
// Directed bench for code_preimage_search: full-scan instance (dut0) and
// early-exit instance (dut1) checked against hand-computed results.
module tb_code_preimage_search;
   import code_preimage_search_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Bench copy of the forward map, written out by hand from the table
   localparam logic [3:0] REF_F [16] = '{
      4'd2, 4'd3, 4'd8, 4'd0, 4'd3, 4'd11, 4'd10, 4'd13,
      4'd9, 4'd15, 4'd12, 4'd7, 4'd1, 4'd2, 4'd1, 4'd4
   };

   logic [1:0]      iv, ordy, ov, ir, of, om;
   logic [1:0][3:0] ic, ox;
   logic [1:0][4:0] oc;

   code_preimage_search_if bus0 ();
   code_preimage_search_if bus1 ();

   code_preimage_search #(.EARLY_EXIT(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   code_preimage_search #(.EARLY_EXIT(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   assign bus0.in_valid  = iv[0];
   assign bus0.in_code   = ic[0];
   assign bus0.out_ready = ordy[0];
   assign bus1.in_valid  = iv[1];
   assign bus1.in_code   = ic[1];
   assign bus1.out_ready = ordy[1];

   assign ov[0] = bus0.out_valid;
   assign ir[0] = bus0.in_ready;
   assign of[0] = bus0.out_found;
   assign ox[0] = bus0.out_x;
   assign oc[0] = bus0.out_count;
   assign om[0] = bus0.out_multi;
   assign ov[1] = bus1.out_valid;
   assign ir[1] = bus1.in_ready;
   assign of[1] = bus1.out_found;
   assign ox[1] = bus1.out_x;
   assign oc[1] = bus1.out_count;
   assign om[1] = bus1.out_multi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic void ref_search(input logic [3:0] y, input bit ee,
                                      output logic f, output logic [3:0] x,
                                      output logic [4:0] c, output int lat);
      f = 1'b0; x = 4'd0; c = 5'd0; lat = 16;
      for (int i = 0; i < 16; i++) begin
         if (REF_F[i] == y && !(ee && f)) begin
            c = c + 5'd1;
            if (!f) begin
               f = 1'b1;
               x = 4'(i);
               if (ee) lat = i + 1;
            end
         end
      end
   endfunction

   task automatic chk_reset_vals(input int d);
      chk("rst_out_valid", 32'(ov[d]), 32'd0);
      chk("rst_in_ready",  32'(ir[d]), 32'd0);
      chk("rst_found",     32'(of[d]), 32'd0);
      chk("rst_x",         32'(ox[d]), 32'd0);
      chk("rst_count",     32'(oc[d]), 32'd0);
      chk("rst_multi",     32'(om[d]), 32'd0);
   endtask

   // Presents a request at a negedge; returns at the negedge after the accept edge
   task automatic start_req(input int d, input logic [3:0] code);
      chk("pre_in_ready", 32'(ir[d]), 32'd1);
      iv[d] = 1'b1;
      ic[d] = code;
      @(negedge clk);
      iv[d] = 1'b0;
      ic[d] = ~code;
      chk("busy_in_ready", 32'(ir[d]), 32'd0);
   endtask

   task automatic wait_result(input int d, input int elat);
      int n = 0;
      while (!ov[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(elat));
   endtask

   task automatic check_res(input int d, input logic f, input logic [3:0] x, input logic [4:0] c);
      chk("found", 32'(of[d]), 32'(f));
      chk("x",     32'(ox[d]), 32'(x));
      chk("count", 32'(oc[d]), 32'(c));
      chk("multi", 32'(om[d]), 32'(c > 5'd1));
   endtask

   task automatic release_res(input int d, input bit rnd);
      int k = 0;
      logic [9:0] held = {of[d], ox[d], oc[d]};
      while (ov[d] && k < 40) begin
         ordy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         k++;
         if (ov[d]) chk("hold", 32'({of[d], ox[d], oc[d]}), 32'(held));
      end
      chk("out_valid_drop", 32'(ov[d]), 32'd0);
      chk("post_in_ready",  32'(ir[d]), 32'd1);
   endtask

   initial begin
      logic       ef;
      logic [3:0] ex;
      logic [4:0] ec;
      int         el;
      bit         seen;
      logic [9:0] held;

      iv = '0; ic = '0; ordy = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals(0);
      chk_reset_vals(1);

      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", 32'(ir[0]), 32'd0);
      @(negedge clk);
      chk("in_ready_after_edge0", 32'(ir[0]), 32'd1);
      chk("in_ready_after_edge1", 32'(ir[1]), 32'd1);

      // Full-scan directed vectors
      ordy[0] = 1'b1;
      start_req(0, 4'd15); wait_result(0, 16); check_res(0, 1'b1, 4'd9,  5'd1); release_res(0, 1'b0);
      start_req(0, 4'd1);  wait_result(0, 16); check_res(0, 1'b1, 4'd12, 5'd2); release_res(0, 1'b0);
      start_req(0, 4'd5);  wait_result(0, 16); check_res(0, 1'b0, 4'd0,  5'd0); release_res(0, 1'b0);

      // Backpressure with request noise while the result is pending
      ordy[0] = 1'b0;
      start_req(0, 4'd3); wait_result(0, 16); check_res(0, 1'b1, 4'd1, 5'd2);
      held = {of[0], ox[0], oc[0]};
      for (int i = 0; i < 10; i++) begin
         iv[0] = i[0];
         ic[0] = 4'(i * 5);
         @(negedge clk);
         chk("bp_out_valid", 32'(ov[0]), 32'd1);
         chk("bp_in_ready",  32'(ir[0]), 32'd0);
         chk("bp_hold",      32'({of[0], ox[0], oc[0]}), 32'(held));
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", 32'(ov[0]), 32'd0);
      chk("bp_release_in_ready",  32'(ir[0]), 32'd1);

      // Reset while searching for 13 (preimage 7 is evaluated at E8)
      start_req(0, 4'd13);
      repeat (7) @(negedge clk);
      chk("mid_found_before_e8", 32'(of[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_found_at_e8", 32'(of[0]), 32'd1);
      chk("mid_x_at_e8",     32'(ox[0]), 32'd7);
      rst_n = 1'b0;
      #1;
      chk_reset_vals(0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_before_edge", 32'(ir[0]), 32'd0);
      @(negedge clk);
      chk("rel_in_ready_after_edge", 32'(ir[0]), 32'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ov[0]) seen = 1'b1;
      end
      chk("stale_out_valid", 32'(seen), 32'd0);
      start_req(0, 4'd2); wait_result(0, 16); check_res(0, 1'b1, 4'd0, 5'd2); release_res(0, 1'b0);

      // Early-exit instance
      ordy[1] = 1'b1;
      start_req(1, 4'd2); wait_result(1, 1);  check_res(1, 1'b1, 4'd0,  5'd1); release_res(1, 1'b0);
      start_req(1, 4'd4); wait_result(1, 16); check_res(1, 1'b1, 4'd15, 5'd1); release_res(1, 1'b0);
      start_req(1, 4'd5); wait_result(1, 16); check_res(1, 1'b0, 4'd0,  5'd0); release_res(1, 1'b0);
      start_req(1, 4'd1); wait_result(1, 13); check_res(1, 1'b1, 4'd12, 5'd1); release_res(1, 1'b0);

      // Back-to-back sweeps of every code with random out_ready
      for (int d = 0; d < 2; d++) begin
         for (int y = 0; y < 16; y++) begin
            ref_search(4'(y), (d == 1), ef, ex, ec, el);
            ordy[d] = 1'($urandom_range(0, 1));
            start_req(d, 4'(y));
            wait_result(d, el);
            check_res(d, ef, ex, ec);
            release_res(d, 1'b1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
